// File: rtl/param_1_to_8_demux_reg_pkg.sv
// param_1_to_8_demux_reg_pkg: shared constants, slot state type and select decode helper
package param_1_to_8_demux_reg_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NUM_CH-1:0] onehot_sel(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/param_demux_slot.sv
// param_demux_slot: one-entry holding register with load/drain and a valid flag
module param_demux_slot
    import param_1_to_8_demux_reg_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [width-1:0] data_i,
    output logic             valid_o,
    output logic [width-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [width-1:0] data_q, data_d;

    // A load wins over a drain so a same-edge drain+load keeps the slot full with the new word
    always_comb begin
        state_d = load_i ? SLOT_FULL : (drain_i ? SLOT_EMPTY : state_q);
        data_d  = load_i ? data_i : data_q;
    end

    // Held word and state; async reset discards any held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/param_1_to_8_demux_reg.sv
// param_1_to_8_demux_reg: registered 1-to-8 demux with per-channel one-entry handshake slots
module param_1_to_8_demux_reg
    import param_1_to_8_demux_reg_pkg::*;
#(
    parameter int width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [width-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_CH*width-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [CNT_W-1:0]        xfer_count
);

    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Ready depends only on the addressed slot, so a stalled consumer blocks only its own words
    always_comb begin
        in_ready = ~out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        load     = accept ? onehot_sel(in_sel) : '0;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, accept};
    end

    // Accepted-word counter, wraps naturally at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign xfer_count = cnt_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        param_demux_slot #(.width(width)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[i]),
            .drain_i (out_ready[i]),
            .data_i  (in_data),
            .valid_o (out_valid[i]),
            .data_o  (out_data[i*width +: width])
        );
    end

endmodule

// File: tb/tb_param_1_to_8_demux_reg.sv
// tb_param_1_to_8_demux_reg: directed and randomized checks against a behavioural channel model
module tb_param_1_to_8_demux_reg;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [15:0]    xfer_count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    logic         m_full [8];
    logic [W-1:0] m_word [8];
    logic [15:0]  m_cnt;

    param_1_to_8_demux_reg #(.width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_ready();
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    function automatic logic [8*W-1:0] m_data_vec();
        logic [8*W-1:0] d;
        for (int i = 0; i < 8; i++) d[i*W +: W] = m_word[i];
        return d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_full[i] <= 1'b0;
                m_word[i] <= '0;
            end
            m_cnt <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (in_valid && m_ready() && in_sel == 3'(i)) begin
                    m_full[i] <= 1'b1;
                    m_word[i] <= in_data;
                end else if (out_ready[i]) begin
                    m_full[i] <= 1'b0;
                end
            end
            if (in_valid && m_ready()) m_cnt <= m_cnt + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("out_valid", 64'(out_valid), 64'(m_valid_vec()));
            chk("out_data", out_data, m_data_vec());
            chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic last_acc;
        rst = 1'b1;
        in_data = '0;
        in_sel = '0;
        in_valid = 1'b0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            chk("rst_in_ready", 64'(in_ready), 64'd1);
        end
        in_sel = '0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle_valid", 64'(out_valid), 64'h00);
        chk("idle_count", 64'(xfer_count), 64'd0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            chk("idle_in_ready", 64'(in_ready), 64'd1);
        end

        in_sel = 3'd3;
        in_data = 8'hA5;
        in_valid = 1'b1;
        out_ready = 8'h00;
        cyc();
        chk("a5_valid", 64'(out_valid), 64'h08);
        chk("a5_slice3", 64'(out_data[3*W +: W]), 64'hA5);
        chk("a5_count", 64'(xfer_count), 64'd1);
        in_data = 8'h5A;
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        cyc();
        cyc();
        chk("stall_slice3", 64'(out_data[3*W +: W]), 64'hA5);
        chk("stall_count", 64'(xfer_count), 64'd1);
        out_ready = 8'h08;
        #1;
        chk("unstall_in_ready", 64'(in_ready), 64'd1);
        cyc();
        chk("reload_slice3", 64'(out_data[3*W +: W]), 64'h5A);
        chk("reload_valid", 64'(out_valid), 64'h08);
        chk("reload_count", 64'(xfer_count), 64'd2);
        in_valid = 1'b0;
        cyc();
        chk("drain3_valid", 64'(out_valid), 64'h00);

        out_ready = 8'h20;
        in_sel = 3'd5;
        for (int w = 1; w <= 3; w++) begin
            in_data = 8'(w);
            in_valid = 1'b1;
            #1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            cyc();
            chk("b2b_slice5", 64'(out_data[5*W +: W]), 64'(w));
            chk("b2b_valid5", 64'(out_valid[5]), 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("b2b_drop5", 64'(out_valid[5]), 64'd0);
        chk("b2b_count", 64'(xfer_count), 64'd5);

        out_ready = 8'h00;
        in_sel = 3'd0;
        in_data = 8'h3C;
        in_valid = 1'b1;
        cyc();
        out_ready = 8'hFE;
        for (int s = 1; s < 8; s++) begin
            in_sel = 3'(s);
            in_data = 8'(s * 17);
            #1;
            chk("ch0stall_in_ready", 64'(in_ready), 64'd1);
            cyc();
        end
        in_valid = 1'b0;
        chk("ch0_slice", 64'(out_data[W-1:0]), 64'h3C);
        chk("ch0_valid", 64'(out_valid[0]), 64'd1);
        chk("ch0_count", 64'(xfer_count), 64'd13);
        out_ready = 8'hFF;
        cyc();
        chk("all_drained", 64'(out_valid), 64'h00);

        out_ready = 8'h00;
        in_valid = 1'b1;
        in_sel = 3'd2;
        in_data = 8'h22;
        cyc();
        in_sel = 3'd6;
        in_data = 8'h66;
        cyc();
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'h44);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'h00);
        chk("async_rst_data", out_data, 64'h0);
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        cyc();
        rst = 1'b0;
        cyc();

        last_acc = 1'b0;
        repeat (3000) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel = 3'($urandom);
                in_data = 8'($urandom);
            end
            out_ready = 8'($urandom);
            last_acc = in_valid && m_ready();
            cyc();
        end

        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 8'hFF;
        repeat (65535) begin
            in_sel = 3'($urandom);
            in_data = 8'($urandom);
            cyc();
        end
        chk("count_ffff", 64'(xfer_count), 64'hFFFF);
        cyc();
        chk("count_wrap", 64'(xfer_count), 64'h0000);
        in_valid = 1'b0;
        cyc();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
